// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction cache combinationally and
// buffers fetched words in an in-order queue toward decode.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_fetch_en,
    input  logic                     i_redirect,
    input  logic [XLEN-1:0]          i_redirect_pc,
    output logic                     o_r_en,
    output logic [XLEN-1:0]          o_fetch_idx,
    input  logic [XLEN-1:0]          i_instruction,
    output logic [XLEN-1:0]          o_pc,
    output logic                     o_instr_valid,
    input  logic                     i_instr_ready,
    output logic [XLEN-1:0]          o_instr,
    output logic [XLEN-1:0]          o_instr_pc,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_misalign
);
    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    logic [XLEN-1:0] pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            misalign;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic            fetch;
    logic            pop;

    // Fetch depends only on registered count, never on i_instr_ready.
    assign fetch = i_fetch_en & ~i_redirect & (count != FULL);
    assign pop   = o_instr_valid & i_instr_ready & ~i_redirect;

    assign o_r_en        = fetch & ~i_rst;
    assign o_fetch_idx   = {2'b00, pc[XLEN-1:2]};
    assign o_pc          = pc;
    assign o_instr_valid = (count != '0);
    assign o_instr       = q_instr[rd_ptr];
    assign o_instr_pc    = q_pc[rd_ptr];
    assign o_count       = count;
    assign o_misalign    = misalign;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (i_redirect) begin
            pc       <= {i_redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= |i_redirect_pc[1:0];
        end else begin
            misalign <= 1'b0;
            if (fetch) begin
                q_instr[wr_ptr] <= i_instruction;
                q_pc[wr_ptr]    <= pc;
                wr_ptr          <= wr_ptr + 1'b1;
                pc              <= pc + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(fetch) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus a
// predictor queue checked by a negedge monitor.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fe = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = '0;
    logic        r_en;
    logic [31:0] idx;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic        valid;
    logic        rdy = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  count;
    logic        mis;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];
    logic [31:0] m_pc = RPC;
    int          m_count = 0;
    logic        m_mis = 1'b0;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_fetch_en(fe),
        .i_redirect(redir),
        .i_redirect_pc(rpc),
        .o_r_en(r_en),
        .o_fetch_idx(idx),
        .i_instruction(instr_in),
        .o_pc(pc),
        .o_instr_valid(valid),
        .i_instr_ready(rdy),
        .o_instr(instr),
        .o_instr_pc(instr_pc),
        .o_count(count),
        .o_misalign(mis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return (a >> 2) ^ 32'h5A00_0000;
    endfunction

    // Cache model: word derived from the requested index.
    assign instr_in = idx ^ 32'h5A00_0000;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Predictor: pushes expected {instr, pc} on every predicted fetch.
    initial forever begin
        logic f;
        logic p;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pc = RPC;
            m_count = 0;
            m_mis = 1'b0;
            sb.delete();
        end else begin
            f = fe & ~redir & (m_count < DEPTH);
            p = (m_count != 0) & rdy & ~redir;
            m_mis = 1'b0;
            if (redir) begin
                sb.delete();
                m_count = 0;
                m_pc = {rpc[31:2], 2'b00};
                m_mis = |rpc[1:0];
            end else begin
                if (f) begin
                    sb.push_back({inst_of(m_pc), m_pc});
                    m_pc = m_pc + 32'd4;
                end
                m_count = m_count + int'(f) - int'(p);
            end
        end
    end

    // Monitor: compares state and pops the scoreboard on each handshake.
    initial forever begin
        logic [63:0] e;
        @(negedge clk);
        if (!rst) begin
            chk("mon_pc", pc, m_pc);
            chk("mon_idx", idx, m_pc >> 2);
            chk("mon_count", 32'(count), 32'(m_count));
            chk("mon_valid", 32'(valid), 32'(m_count != 0));
            chk("mon_r_en", 32'(r_en),
                32'(fe & ~redir & (m_count < DEPTH)));
            chk("mon_mis", 32'(mis), 32'(m_mis));
            if (valid && rdy && !redir) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_instr", instr, e[63:32]);
                    chk("sb_pc", instr_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_pc", pc, 32'h100);
        chk("rst_r_en", 32'(r_en), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_mis", 32'(mis), 0);
        chk("rst_count", 32'(count), 0);
        tick(2);
        rst = 1'b0;

        // 1: streaming with ready high
        fe = 1'b1;
        rdy = 1'b1;
        tick(1);
        chk("t1_pc", pc, 32'h104);
        chk("t1_ipc", instr_pc, 32'h100);
        chk("t1_count", 32'(count), 1);
        tick(3);
        chk("t1_pc3", pc, 32'h110);
        chk("t1_ipc3", instr_pc, 32'h10C);
        chk("t1_count3", 32'(count), 1);

        // 2: back-pressure fills the queue
        rdy = 1'b0;
        redir = 1'b1;
        rpc = 32'h100;
        tick(1);
        redir = 1'b0;
        #1;
        chk("t2_pc0", pc, 32'h100);
        chk("t2_count0", 32'(count), 0);
        chk("t2_ren0", 32'(r_en), 1);
        tick(4);
        chk("t2_full", 32'(count), 4);
        chk("t2_pc_hold", pc, 32'h110);
        chk("t2_ren_full", 32'(r_en), 0);
        chk("t2_head", instr_pc, 32'h100);
        tick(2);
        chk("t2_pc_hold2", pc, 32'h110);
        rdy = 1'b1;
        tick(1);
        chk("t2_count3", 32'(count), 3);
        chk("t2_head1", instr_pc, 32'h104);
        chk("t2_ren_again", 32'(r_en), 1);
        tick(1);
        chk("t2_head2", instr_pc, 32'h108);
        chk("t2_pc_run", pc, 32'h114);

        // 3: redirect with three entries queued
        chk("t3_count", 32'(count), 3);
        redir = 1'b1;
        rpc = 32'h200;
        #1;
        chk("t3_ren_redir", 32'(r_en), 0);
        tick(1);
        redir = 1'b0;
        #1;
        chk("t3_count0", 32'(count), 0);
        chk("t3_valid0", 32'(valid), 0);
        chk("t3_pc", pc, 32'h200);
        chk("t3_ren", 32'(r_en), 1);
        tick(1);
        chk("t3_ipc", instr_pc, 32'h200);
        chk("t3_instr", instr, 32'h5A00_0080);

        // 4: misaligned redirect target
        redir = 1'b1;
        rpc = 32'h203;
        tick(1);
        redir = 1'b0;
        chk("t4_pc", pc, 32'h200);
        chk("t4_mis", 32'(mis), 1);
        tick(1);
        chk("t4_mis_clr", 32'(mis), 0);

        // 5: PC wrap at the top of the address space
        redir = 1'b1;
        rpc = 32'hFFFF_FFFC;
        tick(1);
        redir = 1'b0;
        chk("t5_pc", pc, 32'hFFFF_FFFC);
        chk("t5_idx", idx, 32'h3FFF_FFFF);
        tick(1);
        chk("t5_pc_wrap", pc, 32'h0);
        chk("t5_idx_wrap", idx, 32'h0);
        chk("t5_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("t5_instr", instr, 32'h65FF_FFFF);

        // 6: asynchronous reset mid-run
        rdy = 1'b0;
        redir = 1'b1;
        rpc = 32'h300;
        tick(1);
        redir = 1'b0;
        tick(2);
        chk("t6_count2", 32'(count), 2);
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(valid), 0);
        chk("t6_ren", 32'(r_en), 0);
        chk("t6_pc", pc, 32'h100);
        chk("t6_count", 32'(count), 0);
        chk("t6_instr", instr, 0);
        #3 rst = 1'b0;
        tick(1);
        chk("t6_restart_pc", pc, 32'h104);
        chk("t6_restart_ipc", instr_pc, 32'h100);
        rdy = 1'b1;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
